// File: rtl/test_responder_pkg.sv
// Shared state encoding and default timing constants for the test responder.
package test_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_READY  = 3'd2,
    ST_FILL   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_FILL_CYCLES   = 8;
  localparam int DEF_COUNT_W       = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/test_responder_resp_timer.sv
// Loadable down-counter shared by the SETTLE and FILL phases of the responder.
module resp_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val <= '0;
    end else if (load) begin
      val <= load_val;
    end else if (dec && (val != '0)) begin
      val <= val - W'(1);
    end
  end

  assign zero = (val == '0);

endmodule

// File: rtl/test_responder.sv
// Device-side responder for the start/ready/done test handshake.
// Optional sticky protocol-error flag enabled by RESPONDER_PROTO_CHECK_EN.
module test_responder
  import test_responder_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int FILL_CYCLES   = DEF_FILL_CYCLES,
  parameter int COUNT_W       = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_act,
  input  logic               enable_tub,
  input  logic               count,
  output logic               ready,
  output logic               done,
  output logic               busy,
`ifdef RESPONDER_PROTO_CHECK_EN
  output logic               proto_err,
`endif
  output logic [COUNT_W-1:0] test_cnt
);

  localparam int TIMER_W = $clog2(max2(SETTLE_CYCLES, FILL_CYCLES)) + 1;

  state_e               state;
  state_e               state_nxt;
  logic                 tmr_load;
  logic [TIMER_W-1:0]   tmr_load_val;
  logic                 tmr_dec;
  logic                 tmr_zero;
  logic                 cnt_inc;

  resp_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    cnt_inc      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable_act) begin
          state_nxt    = ST_SETTLE;
          tmr_load     = 1'b1;
          tmr_load_val = TIMER_W'(SETTLE_CYCLES - 1);
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) state_nxt = ST_READY;
        else          tmr_dec   = 1'b1;
      end
      ST_READY: begin
        if (enable_tub) begin
          state_nxt    = ST_FILL;
          tmr_load     = 1'b1;
          tmr_load_val = TIMER_W'(FILL_CYCLES - 1);
        end
      end
      ST_FILL: begin
        if (!enable_tub)   state_nxt = ST_IDLE;
        else if (tmr_zero) state_nxt = ST_DONE;
        else               tmr_dec   = 1'b1;
      end
      ST_DONE: begin
        // The ack wins over a simultaneous enable_tub drop so the test still counts.
        if (count) begin
          state_nxt = ST_IDLE;
          cnt_inc   = 1'b1;
        end else if (!enable_tub) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered decodes of the current state, one edge behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready    <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      test_cnt <= '0;
    end else begin
      ready <= (state == ST_READY) || (state == ST_FILL);
      done  <= (state == ST_DONE);
      busy  <= (state != ST_IDLE);
      if (cnt_inc) test_cnt <= test_cnt + COUNT_W'(1);
    end
  end

`ifdef RESPONDER_PROTO_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err <= 1'b0;
    end else if ((enable_act && (state != ST_IDLE)) ||
                 (count && (state != ST_DONE)) ||
                 (!enable_tub && (state == ST_FILL))) begin
      proto_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_test_responder.sv
// Directed self-checking bench for test_responder (default parameters).
module tb_test_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable_act = 1'b0;
  logic       enable_tub = 1'b0;
  logic       count = 1'b0;
  logic       ready;
  logic       done;
  logic       busy;
  logic [7:0] test_cnt;
`ifdef RESPONDER_PROTO_CHECK_EN
  logic       proto_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  test_responder #(
    .SETTLE_CYCLES (4),
    .FILL_CYCLES   (8),
    .COUNT_W       (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_act (enable_act),
    .enable_tub (enable_tub),
    .count      (count),
    .ready      (ready),
    .done       (done),
    .busy       (busy),
`ifdef RESPONDER_PROTO_CHECK_EN
    .proto_err  (proto_err),
`endif
    .test_cnt   (test_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable_act = 1'b0;
    enable_tub = 1'b0;
    count      = 1'b0;
    rst_n      = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Runs IDLE -> DONE and checks exact ready/done rise edges.
  task automatic drive_to_done(input string tag);
    enable_act = 1'b1;
    step();
    enable_act = 1'b0;
    repeat (4) step();
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL %s_ready_early got %b want 0", tag, ready);
    end
    step();
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL %s_ready_edge5 got %b want 1", tag, ready);
    end
    enable_tub = 1'b1;
    step();
    repeat (8) step();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL %s_done_early got %b want 0", tag, done);
    end
    step();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL %s_done_edge9 got %b want 1", tag, done);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({ready, done, busy, test_cnt} !== 11'd0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got r%b d%b b%b cnt %0d want all 0",
                 i, ready, done, busy, test_cnt);
      end
      step();
    end
  endtask

  task automatic test_full_pass();
    do_reset();
    drive_to_done("pass");
    count = 1'b1;
    step();
    count = 1'b0;
    enable_tub = 1'b0;
    checks++;
    if (test_cnt !== 8'd1) begin
      errors++; $display("FAIL pass_cnt got %0d want 1", test_cnt);
    end
    step();
    step();
    checks++;
    if ({ready, done, busy} !== 3'b000) begin
      errors++; $display("FAIL pass_idle got r%b d%b b%b want 000", ready, done, busy);
    end
  endtask

  task automatic test_fill_abort();
    logic [7:0] cnt0;
    do_reset();
    cnt0 = test_cnt;
    enable_act = 1'b1;
    step();
    enable_act = 1'b0;
    repeat (5) step();
    enable_tub = 1'b1;
    repeat (4) step();
    enable_tub = 1'b0;
    step();
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL abort_idle busy got %b want 0", busy);
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL abort_no_done cyc %0d got %b want 0", i, done);
      end
      step();
    end
    checks++;
    if (test_cnt !== cnt0) begin
      errors++; $display("FAIL abort_cnt got %0d want %0d", test_cnt, cnt0);
    end
`ifdef RESPONDER_PROTO_CHECK_EN
    checks++;
    if (proto_err !== 1'b1) begin
      errors++; $display("FAIL abort_proto_err got %b want 1", proto_err);
    end
`endif
  endtask

  task automatic test_stray();
    do_reset();
`ifdef RESPONDER_PROTO_CHECK_EN
    checks++;
    if (proto_err !== 1'b0) begin
      errors++; $display("FAIL stray_proto_clear got %b want 0", proto_err);
    end
`endif
    enable_act = 1'b1;
    step();
    enable_act = 1'b0;
    repeat (5) step();
    count = 1'b1;
    step();
    count = 1'b0;
    step();
    checks++;
    if ({ready, busy, test_cnt} !== {2'b11, 8'd0}) begin
      errors++; $display("FAIL stray_count_ready got r%b b%b cnt %0d want r1 b1 cnt 0",
                         ready, busy, test_cnt);
    end
    enable_tub = 1'b1;
    step();
    step();
    step();
    enable_act = 1'b1;
    step();
    enable_act = 1'b0;
    repeat (5) step();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL stray_act_done_early got %b want 0", done);
    end
    step();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL stray_act_done_edge9 got %b want 1", done);
    end
    count = 1'b1;
    step();
    count = 1'b0;
    enable_tub = 1'b0;
    checks++;
    if (test_cnt !== 8'd1) begin
      errors++; $display("FAIL stray_cnt got %0d want 1", test_cnt);
    end
    repeat (3) step();
`ifdef RESPONDER_PROTO_CHECK_EN
    checks++;
    if (proto_err !== 1'b1) begin
      errors++; $display("FAIL stray_proto_sticky got %b want 1", proto_err);
    end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    enable_act = 1'b1;
    step();
    enable_act = 1'b0;
    step();
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL async_settle_busy got %b want 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, done, busy} !== 3'b000) begin
      errors++; $display("FAIL async_settle_clear got r%b d%b b%b want 000", ready, done, busy);
    end
    #2 rst_n = 1'b1;
    step();
    drive_to_done("resume1");
    count = 1'b1;
    step();
    count = 1'b0;
    enable_tub = 1'b0;
    step();
    drive_to_done("resume2");
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, done, busy, test_cnt} !== 11'd0) begin
      errors++; $display("FAIL async_done_clear got r%b d%b b%b cnt %0d want all 0",
                         ready, done, busy, test_cnt);
    end
    enable_tub = 1'b0;
    #2 rst_n = 1'b1;
    step();
    drive_to_done("resume3");
    count = 1'b1;
    step();
    count = 1'b0;
    enable_tub = 1'b0;
    checks++;
    if (test_cnt !== 8'd1) begin
      errors++; $display("FAIL async_resume_cnt got %0d want 1", test_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int t = 0; t < 300; t++) begin
      enable_act = 1'b1;
      step();
      enable_act = 1'b0;
      for (int i = 0; i < 20 && ready !== 1'b1; i++) step();
      checks++;
      if (ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready_timeout test %0d got %b want 1", t, ready);
      end
      enable_tub = 1'b1;
      for (int i = 0; i < 20 && done !== 1'b1; i++) step();
      checks++;
      if (done !== 1'b1) begin
        errors++; $display("FAIL b2b_done_timeout test %0d got %b want 1", t, done);
      end
      count = 1'b1;
      step();
      count = 1'b0;
      enable_tub = 1'b0;
      for (int i = 0; i < 5 && busy !== 1'b0; i++) step();
    end
    checks++;
    if (test_cnt !== 8'd44) begin
      errors++; $display("FAIL b2b_cnt_wrap got %0d want 44", test_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_fill_abort();
    test_stray();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
